// File: rtl/div_hi_pkg.sv
// Shared types and constants for the div_hi 64/32 unsigned divider.
package div_hi_pkg;

  localparam int ADDR_W = 8;
  localparam int DIV_ITERATIONS = 32;
  localparam logic [31:0] DIV_SATURATE = 32'hFFFF_FFFF;

  typedef logic [31:0] ia_u32_t;
  typedef logic [ADDR_W-1:0] address_u32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    ia_u32_t      operand1;
    ia_u32_t      operand2;
    ia_u32_t      operand3;
    address_u32_t destination;
    logic         conditionalFlag;
  } div_hi_a;

  function automatic div_hi_a div_hi_o(input ia_u32_t hi, input ia_u32_t lo,
                                       input ia_u32_t dv, input address_u32_t d,
                                       input logic flag);
    div_hi_a r;
    r.operand1        = hi;
    r.operand2        = lo;
    r.operand3        = dv;
    r.destination     = d;
    r.conditionalFlag = flag;
    return r;
  endfunction

endpackage

// File: rtl/div_hi_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_hi_step (
  input  logic [32:0] partial_i,
  input  logic        bit_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] partial_o,
  output logic        qbit_o
);

  logic [33:0] t;
  logic        ge;

  // Partial stays below the divisor, so the top bit of t is zero in practice.
  assign t         = {partial_i, bit_i};
  assign ge        = (t >= {2'b00, divisor_i});
  assign qbit_o    = ge;
  assign partial_o = ge ? 33'(t - {2'b00, divisor_i}) : t[32:0];

endmodule

// File: rtl/div_hi.sv
// Multi-cycle unsigned 64/32 divider with valid/ready handshakes on both sides.
// Optional LCISC_DIV_EARLY_TERM_EN finishes trivially small dividends without iterating.
module div_hi
  import div_hi_pkg::*;
#(
  parameter int DEST_W     = ADDR_W,
  parameter int ITERATIONS = DIV_ITERATIONS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       dividend_hi,
  input  logic [31:0]       dividend_lo,
  input  logic [31:0]       divisor,
  input  logic [DEST_W-1:0] dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       quotient,
  output logic [31:0]       remainder,
  output logic [DEST_W-1:0] out_dest,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam int CNT_W = $clog2(ITERATIONS);

  div_state_e        state_q, state_d;
  logic [32:0]       partial_q, partial_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       divisor_q, divisor_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;

  div_hi_a     req;
  logic [32:0] step_partial;
  logic        step_qbit;

  div_hi_step u_step (
    .partial_i (partial_q),
    .bit_i     (shift_q[31]),
    .divisor_i (divisor_q),
    .partial_o (step_partial),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    partial_d = partial_q;
    shift_d   = shift_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    req = div_hi_o(dividend_hi, dividend_lo, divisor, address_u32_t'(dest),
                   in_valid && (state_q == IDLE));

    case (state_q)
      IDLE: begin
        if (req.conditionalFlag) begin
          dest_d    = DEST_W'(req.destination);
          divisor_d = req.operand3;
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
          if (req.operand3 == '0) begin
            state_d   = DONE;
            shift_d   = DIV_SATURATE;
            partial_d = {1'b0, req.operand2};
            dbz_d     = 1'b1;
          end else if (req.operand1 >= req.operand3) begin
            state_d   = DONE;
            shift_d   = DIV_SATURATE;
            partial_d = {1'b0, req.operand2};
            ovf_d     = 1'b1;
          end
`ifdef LCISC_DIV_EARLY_TERM_EN
          else if ((req.operand1 == '0) && (req.operand2 < req.operand3)) begin
            state_d   = DONE;
            shift_d   = '0;
            partial_d = {1'b0, req.operand2};
          end
`endif
          else begin
            state_d   = RUN;
            partial_d = {1'b0, req.operand1};
            shift_d   = req.operand2;
            cnt_d     = CNT_W'(ITERATIONS - 1);
          end
        end
      end
      RUN: begin
        // Dividend bits leave the top of shift_q as quotient bits enter the bottom.
        partial_d = step_partial;
        shift_d   = {shift_q[30:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      partial_q <= '0;
      shift_q   <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      dest_q    <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      partial_q <= partial_d;
      shift_q   <= shift_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = shift_q;
  assign remainder   = partial_q[31:0];
  assign out_dest    = dest_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_hi.sv
// Scoreboard bench for div_hi: driver pushes expected results, a monitor pops them on each output transfer.
module tb_div_hi;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend_hi, dividend_lo, divisor;
  logic [7:0]  dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient, remainder;
  logic [7:0]  out_dest;
  logic        div_by_zero, overflow;

  div_hi dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend_hi (dividend_hi),
    .dividend_lo (dividend_lo),
    .divisor     (divisor),
    .dest        (dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .out_dest    (out_dest),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [7:0]  d;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_xfer = 0;
  bit   seen = 1'b0;
  int   first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] dv);
    if (dv == 0 || hi >= dv) return 1;
`ifdef LCISC_DIV_EARLY_TERM_EN
    if (hi == 0 && lo < dv) return 1;
`endif
    return 33;
  endfunction

  // Monitor: checks every retired result against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got q=%0h with empty scoreboard", quotient);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("remainder", 64'(remainder), 64'(e.r));
          chk("out_dest", 64'(out_dest), 64'(e.d));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          chk("latency", 64'(first_cyc - e.acc + 1), 64'(e.lat));
          $display("xfer dest=%0h q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d",
                   out_dest, quotient, remainder, div_by_zero, overflow, first_cyc - e.acc + 1);
        end
        seen = 1'b0;
        n_xfer++;
      end
    end
  end

  task automatic issue(input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] dv,
                       input logic [7:0] d, input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input logic eovf);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1; dividend_hi = hi; dividend_lo = lo; divisor = dv; dest = d;
    @(posedge clk); #1;
    e.q = eq; e.r = er; e.d = d; e.dbz = edbz; e.ovf = eovf;
    e.lat = exp_lat(hi, lo, dv);
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    dividend_hi = 32'h0BAD_0BAD; dividend_lo = 32'h0BAD_0BAD; divisor = 32'h0; dest = 8'hEE;
  endtask

  task automatic issue_ref(input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] dv,
                           input logic [7:0] d);
    logic [63:0] n, q, r;
    n = {hi, lo};
    q = n / {32'h0, dv};
    r = n % {32'h0, dv};
    issue(hi, lo, dv, d, q[31:0], r[31:0], 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int x0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend_hi = '0; dividend_lo = '0; divisor = '0; dest = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_out_dest", 64'(out_dest), 64'd0);
    chk("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    @(posedge clk); #1;

    issue(32'd0, 32'd100, 32'd7, 8'h11, 32'd14, 32'd2, 1'b0, 1'b0);
    drain();
    issue(32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 8'h12, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    drain();
    issue(32'd1, 32'd0, 32'd2, 8'h13, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    drain();
    issue(32'd0, 32'd5, 32'd7, 8'h14, 32'd0, 32'd5, 1'b0, 1'b0);
    drain();
    issue(32'd5, 32'h1234, 32'd5, 8'h15, 32'hFFFF_FFFF, 32'h1234, 1'b0, 1'b1);
    drain();
    issue_ref(32'h1234_5678, 32'h9ABC_DEF0, 32'h8765_4321, 8'h16);
    drain();

    // Result held in DONE while the consumer stalls; in_valid pulses must be ignored.
    out_ready = 1'b0;
    issue(32'd7, 32'hDEAD_BEEF, 32'd0, 8'h22, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_quotient", 64'(quotient), 64'hFFFF_FFFF);
      chk("hold_remainder", 64'(remainder), 64'hDEAD_BEEF);
      chk("hold_dest", 64'(out_dest), 64'h22);
      @(posedge clk); #1;
      in_valid = (i % 2 == 0);
      dividend_hi = 32'd0; dividend_lo = 32'd9; divisor = 32'd3; dest = 8'h77;
    end
    in_valid = 1'b0;
    x0 = n_xfer;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("release_one_xfer", 64'(n_xfer - x0), 64'd1);

    // Reset in the middle of RUN discards the in-flight operation.
    issue(32'd0, 32'd100, 32'd7, 8'h33, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (16) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    @(posedge clk); #1;
    issue(32'd0, 32'd100, 32'd7, 8'h5A, 32'd14, 32'd2, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 200; i++) begin
      logic [31:0] dv, hi, lo;
      dv = $urandom;
      if (dv == 0) dv = 32'd1;
      hi = (i % 4 == 0) ? 32'd0 : $urandom_range(dv - 1, 0);
      lo = $urandom;
      issue_ref(hi, lo, dv, 8'(i));
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
